// File: rtl/game_state_ctrl.sv
// Crossing-game sequencer: IDLE/PLAY/WIN/LOSE with lives, seconds countdown, hit cooldown and respawn pulse.
// Optional GAME_STATE_GODMODE_EN: hits still respawn and load the cooldown but never cost a life.
module game_state_ctrl #(
   parameter logic [8:0]  GOAL_Y         = 9'd20,
   parameter int unsigned START_LIVES    = 3,
   parameter int unsigned TIME_LIMIT_S   = 60,
   parameter int unsigned FRAMES_PER_SEC = 60,
   parameter int unsigned HIT_COOLDOWN   = 30
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_start,
   input  logic [8:0] y,
   input  logic       hit,
   output logic [1:0] gameState,
   output logic [1:0] lives,
   output logic [6:0] time_left,
   output logic       respawn
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      WIN  = 2'b10,
      LOSE = 2'b11
   } state_t;

   localparam logic [5:0] FPS_LAST   = 6'(FRAMES_PER_SEC - 1);
   localparam logic [5:0] HIT_CD     = 6'(HIT_COOLDOWN);
   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [6:0] TIME_INIT  = 7'(TIME_LIMIT_S);

   state_t     state_q, state_d;
   logic [2:0] sync_q;
   logic       start_edge;
   logic [5:0] fc_q, fc_d;
   logic [5:0] cd_q, cd_d;
   logic [1:0] lives_d;
   logic [6:0] time_d;
   logic       respawn_d;
   logic       sec_tick, timeout, out_of_lives, hit_take;
   logic [5:0] cd_dec;

   // sync_q[1] is the synchronized level, sync_q[2] its previous value
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[1:0], start};
   end

   assign start_edge = sync_q[1] & ~sync_q[2];

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         lives     <= '0;
         time_left <= '0;
         respawn   <= 1'b0;
         fc_q      <= '0;
         cd_q      <= '0;
      end else begin
         state_q   <= state_d;
         lives     <= lives_d;
         time_left <= time_d;
         respawn   <= respawn_d;
         fc_q      <= fc_d;
         cd_q      <= cd_d;
      end
   end

   assign gameState = state_q;

   always_comb begin
      state_d      = state_q;
      lives_d      = lives;
      time_d       = time_left;
      respawn_d    = 1'b0;
      fc_d         = fc_q;
      cd_d         = cd_q;
      sec_tick     = 1'b0;
      timeout      = 1'b0;
      out_of_lives = 1'b0;
      hit_take     = 1'b0;
      cd_dec       = cd_q;

      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d   = PLAY;
               lives_d   = LIVES_INIT;
               time_d    = TIME_INIT;
               fc_d      = '0;
               cd_d      = '0;
               respawn_d = 1'b1;
            end
         end
         PLAY: begin
            if (frame_start) begin
               sec_tick = (fc_q == FPS_LAST);
               fc_d     = sec_tick ? '0 : fc_q + 6'd1;
               if (sec_tick && time_left != '0) time_d = time_left - 7'd1;
               timeout  = sec_tick && (time_left == 7'd1);

               // hit is judged against the already-decremented cooldown
               cd_dec   = (cd_q != '0) ? cd_q - 6'd1 : '0;
               cd_d     = cd_dec;
               hit_take = hit && (cd_dec == '0);
               if (hit_take) begin
                  cd_d      = HIT_CD;
                  respawn_d = 1'b1;
`ifdef GAME_STATE_GODMODE_EN
                  out_of_lives = 1'b0;
`else
                  if (lives > 2'd1) begin
                     lives_d = lives - 2'd1;
                  end else begin
                     lives_d      = '0;
                     out_of_lives = 1'b1;
                  end
`endif
               end

               if (y <= GOAL_Y)                  state_d = WIN;
               else if (timeout || out_of_lives) state_d = LOSE;
            end
         end
         WIN, LOSE: begin
            if (start_edge) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: three parameterisations share stimulus, each checked where relevant.
module tb_game_state_ctrl;

`ifdef GAME_STATE_GODMODE_EN
   localparam bit GOD = 1'b1;
`else
   localparam bit GOD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, start, frame_start, hit;
   logic [8:0] y;

   logic [1:0] gs_a, lv_a, gs_b, lv_b, gs_c, lv_c;
   logic [6:0] tl_a, tl_b, tl_c;
   logic       rs_a, rs_b, rs_c;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned rs_cnt = 0;

   always #10 clk = ~clk;

   // fast clock: 4 frames per second, 2 second game
   game_state_ctrl #(.FRAMES_PER_SEC(4), .TIME_LIMIT_S(2)) dut_a (
      .CLOCK_50(clk), .reset(rst_n), .start(start), .frame_start(frame_start),
      .y(y), .hit(hit), .gameState(gs_a), .lives(lv_a), .time_left(tl_a), .respawn(rs_a));

   game_state_ctrl dut_b (
      .CLOCK_50(clk), .reset(rst_n), .start(start), .frame_start(frame_start),
      .y(y), .hit(hit), .gameState(gs_b), .lives(lv_b), .time_left(tl_b), .respawn(rs_b));

   game_state_ctrl #(.START_LIVES(1)) dut_c (
      .CLOCK_50(clk), .reset(rst_n), .start(start), .frame_start(frame_start),
      .y(y), .hit(hit), .gameState(gs_c), .lives(lv_c), .time_left(tl_c), .respawn(rs_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [8:0] yy, input logic hh);
      y = yy;
      hit = hh;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      hit = 1'b0;
      y = 9'd450;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic start_game();
      start = 1'b1;
      step();
      step();
      chk("idle_until_edge3", gs_b, 0);
      step();
      chk("start_state", gs_b, 1);
      chk("start_lives", lv_b, 3);
      chk("start_time", tl_b, 60);
      chk("start_respawn", rs_b, 1);
      start = 1'b0;
      step();
      chk("start_respawn_end", rs_b, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      frame_start = 1'b0;
      hit = 1'b0;
      y = 9'd450;
      repeat (3) step();
      chk("rst_state", gs_b, 0);
      chk("rst_lives", lv_b, 0);
      chk("rst_time", tl_b, 0);
      chk("rst_respawn", rs_b, 0);
      rst_n = 1'b1;
      step();
      step();
      chk("post_rst_state", gs_b, 0);
      start_game();

      // timeout on the 2-second instance
      repeat (4) frame(9'd450, 1'b0);
      chk("to_time1", tl_a, 1);
      chk("to_state_play", gs_a, 1);
      chk("to_lives", lv_a, 3);
      repeat (4) frame(9'd450, 1'b0);
      chk("to_time0", tl_a, 0);
      chk("to_state_lose", gs_a, 3);
      chk("to_respawn", rs_a, 0);

      do_reset();
      start_game();

      // hit held for 40 frames
      for (int k = 1; k <= 40; k++) begin
         frame(9'd450, 1'b1);
         rs_cnt += 32'(rs_b);
         if (k == 1) begin
            chk("hit1_lives", lv_b, GOD ? 3 : 2);
            chk("hit1_respawn", rs_b, 1);
            chk("c_hit1_lives", lv_c, GOD ? 1 : 0);
            chk("c_hit1_state", gs_c, GOD ? 1 : 3);
            chk("c_hit1_respawn", rs_c, 1);
            chk("c_hit1_time", tl_c, 60);
         end
         if (k == 30) chk("cool30_lives", lv_b, GOD ? 3 : 2);
         if (k == 31) begin
            chk("hit31_lives", lv_b, GOD ? 3 : 1);
            chk("hit31_respawn", rs_b, 1);
         end
      end
      chk("hit_respawn_count", rs_cnt, 2);
      chk("hit_state", gs_b, 1);

      // goal and hit on the last life in the same frame
      repeat (20) frame(9'd450, 1'b0);
      chk("sec_tick_time", tl_b, 59);
      frame(9'd20, 1'b1);
      chk("goal_state", gs_b, 2);
      chk("goal_lives", lv_b, GOD ? 3 : 0);
      chk("goal_respawn", rs_b, 1);
      chk("goal_time", tl_b, 59);
      frame(9'd450, 1'b1);
      chk("win_frozen_lives", lv_b, GOD ? 3 : 0);
      chk("win_frozen_respawn", rs_b, 0);
      chk("win_frozen_state", gs_b, 2);

      // start back to IDLE keeps lives/time visible
      start = 1'b1;
      repeat (3) step();
      start = 1'b0;
      chk("win_to_idle", gs_b, 0);
      chk("idle_lives_kept", lv_b, GOD ? 3 : 0);
      chk("idle_time_kept", tl_b, 59);
      repeat (3) step();

      // reset in the middle of a game acts without a clock edge
      start_game();
      frame(9'd450, 1'b1);
      chk("mid_hit_lives", lv_b, GOD ? 3 : 2);
      #5;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", gs_b, 0);
      chk("async_rst_lives", lv_b, 0);
      chk("async_rst_time", tl_b, 0);
      chk("async_rst_respawn", rs_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
